reg_ctx_ctrl: RTL and testbench

Context save/restore sequencer for the 8 x 8-bit register file. On a START it takes control of register-file read port 1 and the write port, and moves all eight registers to or from an 8-byte block in data memory through the memory read/write/busywait handshake. While it runs, CPU_STALL freezes the core. The top-level muxes these port signals into the register file while BUSY=1.

---
 rtl/reg_ctx_ctrl_pkg.sv | 17 +
 rtl/reg_ctx_ctrl_if.sv | 36 +++
 rtl/reg_ctx_ctrl.sv | 118 +++++++++++
 tb/tb_reg_ctx_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_ctx_ctrl_pkg.sv
// Shared sizes, state encoding and block-address helper for the
// register-context save/restore sequencer.
package reg_ctx_ctrl_pkg;
   localparam int NREGS = 8;
   localparam int IDX_W = 3;
   localparam int DW    = 8;
   localparam int AW    = 8;

   typedef enum logic [2:0] {IDLE, S_RD, S_MW, R_MR, R_WR, FIN} state_e;
   typedef enum logic {MODE_SAVE = 1'b0, MODE_RESTORE = 1'b1} mode_e;
   typedef logic [IDX_W-1:0] idx_t;

   // Context block address; wraps modulo 2^AW.
   function automatic logic [AW-1:0] blk_addr(logic [AW-1:0] base, idx_t idx);
      return base + AW'(idx);
   endfunction
endpackage

// File: rtl/reg_ctx_ctrl_if.sv
// Control, register-file and data-memory signals of the context sequencer.
interface reg_ctx_ctrl_if;
   import reg_ctx_ctrl_pkg::*;

   logic          START;
   logic          MODE;
   logic [AW-1:0] BASE_ADDR;
   logic          BUSY;
   logic          DONE;
   logic          CPU_STALL;

   logic [2:0]    RF_OUT1ADDRESS;
   logic [DW-1:0] RF_OUT1;
   logic [2:0]    RF_INADDRESS;
   logic [DW-1:0] RF_IN;
   logic          RF_WRITE;

   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_WRITEDATA;
   logic [DW-1:0] MEM_READDATA;
   logic          MEM_READ;
   logic          MEM_WRITE;
   logic          MEM_BUSYWAIT;

   modport master (
      input  START, MODE, BASE_ADDR, RF_OUT1, MEM_READDATA, MEM_BUSYWAIT,
      output BUSY, DONE, CPU_STALL, RF_OUT1ADDRESS, RF_INADDRESS, RF_IN, RF_WRITE,
             MEM_ADDR, MEM_WRITEDATA, MEM_READ, MEM_WRITE
   );

   modport slave (
      output START, MODE, BASE_ADDR, RF_OUT1, MEM_READDATA, MEM_BUSYWAIT,
      input  BUSY, DONE, CPU_STALL, RF_OUT1ADDRESS, RF_INADDRESS, RF_IN, RF_WRITE,
             MEM_ADDR, MEM_WRITEDATA, MEM_READ, MEM_WRITE
   );
endinterface

// File: rtl/reg_ctx_ctrl.sv
// Moves all registers to/from an 8-byte memory block while stalling the core.
// Every output is a register updated alongside the state, so requests are glitch-free.
module reg_ctx_ctrl
   import reg_ctx_ctrl_pkg::*;
(
   input logic            CLK,
   input logic            RESET,
   reg_ctx_ctrl_if.master bus
);
   state_e        state_q;
   idx_t          idx_q, idx_d;
   logic [AW-1:0] base_q, addr_d;
   logic          last_d;

   logic          busy_q, done_q, rf_we_q, mem_rd_q, mem_wr_q;
   idx_t          rd_addr_q, wr_addr_q;
   logic [DW-1:0] rf_in_q, mem_wd_q;
   logic [AW-1:0] mem_addr_q;

   assign idx_d  = idx_q + 1'b1;
   assign last_d = (idx_q == IDX_W'(NREGS-1));
   assign addr_d = blk_addr(base_q, idx_d);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rf_we_q    <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         rf_in_q    <= '0;
         mem_wd_q   <= '0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.START) begin
                  base_q <= bus.BASE_ADDR;
                  idx_q  <= '0;
                  busy_q <= 1'b1;
                  if (bus.MODE == MODE_SAVE) begin
                     rd_addr_q <= '0;
                     state_q   <= S_RD;
                  end else begin
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= bus.BASE_ADDR;
                     state_q    <= R_MR;
                  end
               end
            end
            // RF_OUT1 has had the whole S_RD cycle to settle; it is captured at this edge.
            S_RD: begin
               mem_wr_q   <= 1'b1;
               mem_addr_q <= blk_addr(base_q, idx_q);
               mem_wd_q   <= bus.RF_OUT1;
               state_q    <= S_MW;
            end
            S_MW: begin
               if (!bus.MEM_BUSYWAIT) begin
                  mem_wr_q <= 1'b0;
                  if (last_d) begin
                     done_q  <= 1'b1;
                     state_q <= FIN;
                  end else begin
                     idx_q     <= idx_d;
                     rd_addr_q <= idx_d;
                     state_q   <= S_RD;
                  end
               end
            end
            R_MR: begin
               if (!bus.MEM_BUSYWAIT) begin
                  mem_rd_q  <= 1'b0;
                  rf_we_q   <= 1'b1;
                  wr_addr_q <= idx_q;
                  rf_in_q   <= bus.MEM_READDATA;
                  state_q   <= R_WR;
               end
            end
            R_WR: begin
               rf_we_q <= 1'b0;
               if (last_d) begin
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  idx_q      <= idx_d;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= addr_d;
                  state_q    <= R_MR;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.BUSY           = busy_q;
   assign bus.CPU_STALL      = busy_q;
   assign bus.DONE           = done_q;
   assign bus.RF_OUT1ADDRESS = rd_addr_q;
   assign bus.RF_INADDRESS   = wr_addr_q;
   assign bus.RF_IN          = rf_in_q;
   assign bus.RF_WRITE       = rf_we_q;
   assign bus.MEM_ADDR       = mem_addr_q;
   assign bus.MEM_WRITEDATA  = mem_wd_q;
   assign bus.MEM_READ       = mem_rd_q;
   assign bus.MEM_WRITE      = mem_wr_q;
endmodule

// File: tb/tb_reg_ctx_ctrl.sv
// Bench for reg_ctx_ctrl: register-file and memory models around the DUT,
// a table of directed transfers, reset corner cases and randomized transfers.
module tb_reg_ctx_ctrl;
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   reg_ctx_ctrl_if bus();
   reg_ctx_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   typedef struct packed { logic [7:0] a; logic [7:0] d; } xact_t;
   typedef struct { bit mode; logic [7:0] base; int wt; int exp_busy; bit extra; } vec_t;

   int checks = 0, errors = 0;
   logic [7:0] rf [8];
   logic [7:0] mem [256];
   xact_t wlog[$], rlog[$];
   int stall_left, wait_fix, wait_max, waits, mux_err, stab_err;
   bit wait_rand;
   vec_t tbl [7];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [35:0] outs();
      return {bus.BUSY, bus.DONE, bus.CPU_STALL, bus.RF_WRITE, bus.MEM_READ, bus.MEM_WRITE,
              bus.RF_OUT1ADDRESS, bus.RF_INADDRESS, bus.RF_IN, bus.MEM_ADDR, bus.MEM_WRITEDATA};
   endfunction

   function automatic int next_wait();
      return wait_rand ? int'($urandom_range(wait_max, 0)) : wait_fix;
   endfunction

   // One clock: called at negedge, drives the model responses, applies the edge, samples at negedge.
   task automatic cyc();
      bit req, acc, mw, rw, stalled;
      xact_t mx, rx;
      logic [17:0] preq;
      bus.RF_OUT1      = rf[bus.RF_OUT1ADDRESS];
      bus.MEM_READDATA = mem[bus.MEM_ADDR];
      req = bus.MEM_READ || bus.MEM_WRITE;
      bus.MEM_BUSYWAIT = req && (stall_left > 0);
      if (bus.MEM_BUSYWAIT) begin stall_left--; waits++; end
      acc     = req && !bus.MEM_BUSYWAIT;
      mw      = acc && bus.MEM_WRITE;
      mx      = {bus.MEM_ADDR, bus.MEM_WRITEDATA};
      rw      = bus.RF_WRITE;
      rx      = {5'b0, bus.RF_INADDRESS, bus.RF_IN};
      stalled = bus.MEM_BUSYWAIT && !RESET;
      preq    = {bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_WRITEDATA};
      @(posedge CLK);
      if (mw) begin mem[mx.a] = mx.d; wlog.push_back(mx); end
      if (acc) stall_left = next_wait();
      if (rw) begin rf[rx.a[2:0]] = rx.d; rlog.push_back(rx); end
      @(negedge CLK);
      if (bus.MEM_READ && bus.MEM_WRITE) mux_err++;
      if (bus.RF_WRITE && (bus.MEM_READ || bus.MEM_WRITE)) mux_err++;
      if (bus.CPU_STALL !== bus.BUSY) mux_err++;
      if (stalled && ({bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR, bus.MEM_WRITEDATA} !== preq))
         stab_err++;
   endtask

   // exp_busy < 0: expected BUSY length comes from the rule 17 + inserted wait cycles.
   task automatic run_xfer(string nm, bit mode, logic [7:0] base, int exp_busy, bit extra);
      logic [7:0] rf0 [8];
      logic [7:0] mem0 [256];
      logic [7:0] a;
      int busy_n, done_n, done_at, bad, expb;
      bit fin;
      rf0 = rf; mem0 = mem;
      wlog.delete(); rlog.delete();
      waits = 0; mux_err = 0; stab_err = 0; stall_left = next_wait();
      busy_n = 0; done_n = 0; done_at = 0; fin = 0;
      bus.START = 1'b1; bus.MODE = mode; bus.BASE_ADDR = base;
      for (int n = 0; n < 1000 && !fin; n++) begin
         cyc();
         bus.START     = extra && (n == 2 || n == 9);
         bus.MODE      = 1'($urandom);
         bus.BASE_ADDR = 8'($urandom);
         if (bus.BUSY) busy_n++;
         if (bus.DONE) begin done_n++; done_at = busy_n; end
         if (done_n > 0 && !bus.BUSY) fin = 1;
      end
      bus.START = 1'b0;
      expb = (exp_busy < 0) ? 17 + waits : exp_busy;
      chk({nm, "_finished"}, fin, 1);
      chk({nm, "_busy_cycles"}, busy_n, expb);
      chk({nm, "_done_count"}, done_n, 1);
      chk({nm, "_done_cycle"}, done_at, expb);
      bad = 0;
      if (mode == 1'b0) begin
         if (wlog.size() != 8 || rlog.size() != 0) bad++;
         else for (int i = 0; i < 8; i++) begin
            a = base + 8'(i);
            if (wlog[i] !== {a, rf0[i]} || mem[a] !== rf0[i]) bad++;
         end
      end else begin
         if (rlog.size() != 8 || wlog.size() != 0) bad++;
         else for (int i = 0; i < 8; i++) begin
            a = base + 8'(i);
            if (rlog[i] !== {8'(i), mem0[a]} || rf[i] !== mem0[a]) bad++;
         end
      end
      chk({nm, "_data_errs"}, bad, 0);
      chk({nm, "_excl_errs"}, mux_err, 0);
      chk({nm, "_stall_hold_errs"}, stab_err, 0);
   endtask

   task automatic preload(logic [7:0] base);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         rf[i] = 8'h10 + 8'(i);
         mem[8'(base + 8'(i))] = 8'hA0 + 8'(i);
      end
   endtask

   initial begin
      bit hit;
      int dn;
      tbl[0] = '{0, 8'h40, 0, 17, 0};
      tbl[1] = '{1, 8'h80, 0, 17, 0};
      tbl[2] = '{0, 8'h40, 3, 41, 0};
      tbl[3] = '{1, 8'hFE, 0, 17, 0};
      tbl[4] = '{0, 8'hFC, 1, 25, 0};
      tbl[5] = '{1, 8'h10, 2, 33, 0};
      tbl[6] = '{0, 8'h20, 0, 17, 1};

      bus.START = 0; bus.MODE = 0; bus.BASE_ADDR = 0;
      bus.RF_OUT1 = 0; bus.MEM_READDATA = 0; bus.MEM_BUSYWAIT = 0;
      wait_rand = 0; wait_fix = 0; wait_max = 0; stall_left = 0;
      preload(8'h00);
      RESET = 1'b1;
      @(negedge CLK);
      cyc(); cyc();
      chk("reset_outputs", outs(), 0);
      RESET = 1'b0;
      cyc();
      chk("idle_outputs", outs(), 0);

      foreach (tbl[k]) begin
         wait_rand = 0; wait_fix = tbl[k].wt;
         preload(tbl[k].base);
         run_xfer($sformatf("vec%0d", k), tbl[k].mode, tbl[k].base, tbl[k].exp_busy, tbl[k].extra);
         if (tbl[k].mode) chk($sformatf("vec%0d_R5", k), rf[5], 8'hA5);
         cyc();
         chk($sformatf("vec%0d_after_idle", k), {bus.BUSY, bus.DONE, bus.RF_WRITE, bus.MEM_READ, bus.MEM_WRITE}, 0);
      end

      // Reset while the fourth memory write is on the bus.
      wait_rand = 0; wait_fix = 0; stall_left = 0;
      preload(8'h40); wlog.delete();
      bus.START = 1; bus.MODE = 0; bus.BASE_ADDR = 8'h40;
      cyc();
      bus.START = 0;
      hit = 0;
      for (int n = 0; n < 40 && !hit; n++) begin
         if (bus.MEM_WRITE && wlog.size() == 3) begin RESET = 1'b1; hit = 1; end
         cyc();
      end
      RESET = 1'b0;
      chk("midop_reset_hit", hit, 1);
      chk("midop_reset_outputs", outs(), 0);
      dn = 0;
      for (int n = 0; n < 5; n++) begin cyc(); dn += int'(bus.DONE) + int'(bus.BUSY); end
      chk("midop_reset_quiet", dn, 0);
      preload(8'h40);
      run_xfer("post_reset_save", 0, 8'h40, 17, 0);

      // RESET beats START in the same cycle.
      RESET = 1'b1; bus.START = 1; bus.MODE = 1; bus.BASE_ADDR = 8'h33;
      cyc();
      RESET = 1'b0; bus.START = 0;
      chk("reset_start_outputs", outs(), 0);
      cyc();
      chk("reset_start_idle", {bus.BUSY, bus.MEM_READ}, 0);

      wait_rand = 1; wait_max = 3;
      for (int k = 0; k < 12; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
         run_xfer($sformatf("rnd%0d", k), 1'($urandom), b, -1, 1'($urandom));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
